// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          FETCH_INSTR_WIDTH = 32;
    localparam int          FETCH_ADDR_WIDTH  = 32;
    localparam logic [31:0] FETCH_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_INSTR_WIDTH-1:0] instr;
        logic [FETCH_ADDR_WIDTH-1:0]  pc;
        logic [FETCH_ADDR_WIDTH-1:0]  pcplus4;
        logic                         misaligned;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue_if
//  Description : PC, instruction-memory and decode handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_queue_if #(
    parameter int DATA_WIDTH = 32
);
    import fetch_pkg::*;

    logic [DATA_WIDTH-1:0]        pc;
    logic [DATA_WIDTH-1:0]        pcplus4;
    logic                         flush;
    logic                         imem_req;
    logic [DATA_WIDTH-1:0]        imem_addr;
    logic [FETCH_INSTR_WIDTH-1:0] imem_rdata;
    logic                         pc_stall;
    logic                         id_valid;
    logic                         id_ready;
    logic [FETCH_INSTR_WIDTH-1:0] id_instr;
    logic [DATA_WIDTH-1:0]        id_pc;
    logic [DATA_WIDTH-1:0]        id_pcplus4;
    logic                         id_misaligned;

    modport slave (
        input  pc, pcplus4, flush, imem_rdata, id_ready,
        output imem_req, imem_addr, pc_stall,
               id_valid, id_instr, id_pc, id_pcplus4, id_misaligned
    );

    modport master (
        output pc, pcplus4, flush, imem_rdata, id_ready,
        input  imem_req, imem_addr, pc_stall,
               id_valid, id_instr, id_pc, id_pcplus4, id_misaligned
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Power-of-two FIFO of fetch entries with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               entry_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Clear wins over push/pop so a redirect leaves no stale entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Credit-based instruction fetch queue between PC and decode.
//                FETCH_MISALIGN_CHECK_EN adds a per-entry misaligned-PC flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [CNT_W-1:0]      count;
    logic [OCC_W-1:0]      occ;
    logic                  id_valid;
    logic                  pop;
    logic                  issue;
    logic                  drop;
    logic                  push;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  misaligned_q, misaligned_d;
`endif

    // Credit: queued + in-flight - leaving must leave room for one more return.
    always_comb begin
        id_valid   = (count != '0);
        pop        = id_valid & bus.id_ready;
        occ        = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue      = rst & ~bus.flush & (occ < OCC_W'(DEPTH));
        drop       = bus.flush & inflight_q;
        push       = inflight_q & ~drop;
        inflight_d = issue;
        pc_d       = issue ? bus.pc      : pc_q;
        pcplus4_d  = issue ? bus.pcplus4 : pcplus4_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned_d = issue ? (bus.pc[1:0] != 2'b00) : misaligned_q;
`endif
        push_entry.instr   = bus.imem_rdata;
        push_entry.pc      = FETCH_ADDR_WIDTH'(pc_q);
        push_entry.pcplus4 = FETCH_ADDR_WIDTH'(pcplus4_q);
`ifdef FETCH_MISALIGN_CHECK_EN
        push_entry.misaligned = misaligned_q;
`else
        push_entry.misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            pc_q       <= '0;
            pcplus4_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
            pcplus4_q  <= pcplus4_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .clear_i (bus.flush),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = bus.pc;
    assign bus.pc_stall   = ~rst | (~issue & ~bus.flush);
    assign bus.id_valid   = id_valid;
    assign bus.id_instr   = head.instr;
    assign bus.id_pc      = DATA_WIDTH'(head.pc);
    assign bus.id_pcplus4 = DATA_WIDTH'(head.pcplus4);
`ifdef FETCH_MISALIGN_CHECK_EN
    assign bus.id_misaligned = head.misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = head.misaligned;
    assign bus.id_misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Randomised scoreboard bench for instr_fetch_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(.DATA_WIDTH(DW)) bus();

    instr_fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: returned-but-unconsumed entries, plus the one outstanding read.
    fetch_entry_t exp_q[$];
    fetch_entry_t m_pending;
    logic         m_inflight = 1'b0;
    logic         req_s      = 1'b0;
    logic         stall_s    = 1'b1;
    logic [31:0]  addr_s     = '0;
    logic [31:0]  flush_tgt  = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic exp_mis(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: registered read, data valid the cycle after the request.
    always @(posedge clk) begin
        #1;
        bus.imem_rdata = req_s ? memfn(addr_s) : FETCH_NOP;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        logic m_pop;
        logic m_issue;
        int   occ;
        req_s   = bus.imem_req;
        addr_s  = bus.imem_addr;
        stall_s = bus.pc_stall;
        if (!rst) begin
            check("rst_id_valid",   32'(bus.id_valid),      32'd0);
            check("rst_imem_req",   32'(bus.imem_req),      32'd0);
            check("rst_pc_stall",   32'(bus.pc_stall),      32'd1);
            check("rst_id_instr",   bus.id_instr,           32'd0);
            check("rst_id_pc",      bus.id_pc,              32'd0);
            check("rst_id_pcplus4", bus.id_pcplus4,         32'd0);
            check("rst_id_mis",     32'(bus.id_misaligned), 32'd0);
            exp_q.delete();
            m_inflight = 1'b0;
        end else begin
            m_pop = (exp_q.size() != 0) && bus.id_ready;
            check("id_valid", 32'(bus.id_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("id_instr",   bus.id_instr,           exp_q[0].instr);
                check("id_pc",      bus.id_pc,              exp_q[0].pc);
                check("id_pcplus4", bus.id_pcplus4,         exp_q[0].pcplus4);
                check("id_mis",     32'(bus.id_misaligned), 32'(exp_q[0].misaligned));
            end
            occ     = exp_q.size() + int'(m_inflight) - int'(m_pop);
            m_issue = !bus.flush && (occ < DEPTH);
            check("imem_req",  32'(bus.imem_req), 32'(m_issue));
            check("pc_stall",  32'(bus.pc_stall), 32'(!m_issue && !bus.flush));
            check("imem_addr", bus.imem_addr,     bus.pc);
            if (m_pop) void'(exp_q.pop_front());
            if (bus.flush) begin
                exp_q.delete();
            end else if (m_inflight) begin
                exp_q.push_back(m_pending);
            end
            if (exp_q.size() > DEPTH) begin
                errors++;
                $display("FAIL overflow: got %0d entries expected at most %0d", exp_q.size(), DEPTH);
            end
            if (m_issue) begin
                m_pending = '{instr: memfn(bus.pc), pc: bus.pc, pcplus4: bus.pc + 32'd4,
                              misaligned: exp_mis(bus.pc)};
            end
            m_inflight = m_issue;
        end
    end

    // One clock of stimulus: advance the PC as the real PC stage would, then drive.
    task automatic step(input logic rdy, input logic fl, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        if (!rst)             bus.pc = '0;
        else if (bus.flush)   bus.pc = flush_tgt;
        else if (!stall_s)    bus.pc = bus.pc + 32'd4;
        bus.pcplus4 = bus.pc + 32'd4;
        bus.id_ready = rdy;
        bus.flush    = fl;
        flush_tgt    = tgt;
    endtask

    initial begin
        logic [31:0] tgt;
        bus.pc         = '0;
        bus.pcplus4    = 32'd4;
        bus.flush      = 1'b0;
        bus.id_ready   = 1'b0;
        bus.imem_rdata = FETCH_NOP;

        repeat (3) step(1'b1, 1'b0, '0);
        rst = 1'b1;

        // Streaming
        repeat (10) step(1'b1, 1'b0, '0);
        // Back-pressure then release
        repeat (6) step(1'b0, 1'b0, '0);
        repeat (4) step(1'b1, 1'b0, '0);
        // Fill, then redirect while full with a read outstanding
        step(1'b0, 1'b1, 32'h10);
        repeat (4) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h100);
        repeat (4) step(1'b1, 1'b0, '0);
        // Redirect with a pop in the same cycle
        step(1'b1, 1'b1, 32'h40);
        repeat (3) step(1'b1, 1'b0, '0);
        // Misaligned target
        step(1'b1, 1'b1, 32'h102);
        repeat (5) step(1'b1, 1'b0, '0);

        // Asynchronous reset with one entry queued and one read outstanding
        step(1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        #2;
        check("pre_reset_valid", 32'(bus.id_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset_valid", 32'(bus.id_valid), 32'd0);
        repeat (2) step(1'b1, 1'b0, '0);
        rst = 1'b1;
        repeat (6) step(1'b1, 1'b0, '0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = {16'h0, 14'($urandom), 2'b00};
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), tgt);
        end
        step(1'b1, 1'b0, '0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
